match_sequencer: RTL and testbench

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/match_sequencer_if.sv | 41 ++++
 rtl/match_sequencer.sv | 140 ++++++++++++++
 tb/tb_match_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/match_sequencer_if.sv
// Bus bundle for match_sequencer: control pulses, live positions in, frame-stable
// positions and match status out.
interface match_sequencer_if;
    logic       start;
    logic       pause;
    logic       frame_end;
    logic       goal_team1;
    logic       goal_team2;
    logic [9:0] ball_x_in;
    logic [9:0] ball_y_in;
    logic [9:0] team1_ver_in;
    logic [9:0] team1_hor_in;
    logic [9:0] team2_ver_in;
    logic [9:0] team2_hor_in;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] team1_ver_pos;
    logic [9:0] team1_hor_pos;
    logic [9:0] team2_ver_pos;
    logic [9:0] team2_hor_pos;
    logic [7:0] left_seconds;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] state;
    logic       game_over;
    logic       freeze;

    modport master (
        output start, pause, frame_end, goal_team1, goal_team2,
               ball_x_in, ball_y_in, team1_ver_in, team1_hor_in, team2_ver_in, team2_hor_in,
        input  ball_x, ball_y, team1_ver_pos, team1_hor_pos, team2_ver_pos, team2_hor_pos,
               left_seconds, score1, score2, state, game_over, freeze
    );

    modport slave (
        input  start, pause, frame_end, goal_team1, goal_team2,
               ball_x_in, ball_y_in, team1_ver_in, team1_hor_in, team2_ver_in, team2_hor_in,
        output ball_x, ball_y, team1_ver_pos, team1_hor_pos, team2_ver_pos, team2_hor_pos,
               left_seconds, score1, score2, state, game_over, freeze
    );
endinterface

// File: rtl/match_sequencer.sv
// Match timer/score sequencer with frame-latched positions.
// Define GOAL_HOLD_EN to pause play for HOLD_FRAMES frames after each goal.
module match_sequencer #(
    parameter int CLK_HZ        = 50000000,
    parameter int MATCH_SECONDS = 180,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    match_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GOAL_HOLD = 2'd2, OVER = 2'd3} state_t;

    localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
    localparam logic [7:0]       MATCH_LD = 8'(MATCH_SECONDS);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       left_q, left_d;
    logic [3:0]       s1_q, s1_d, s2_q, s2_d;
    logic             game_over_q, freeze_q;
    logic [5:0][9:0]  pos_q;
    logic             tick;

`ifdef GOAL_HOLD_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    logic [7:0] hold_q, hold_d;
    logic       goal_any;
    assign goal_any = bus.goal_team1 | bus.goal_team2;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        left_d  = left_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        tick    = 1'b0;
`ifdef GOAL_HOLD_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    left_d  = MATCH_LD;
                    s1_d    = 4'd0;
                    s2_d    = 4'd0;
                    div_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.pause) begin
                    if (div_q == DIV_MAX) begin
                        div_d = '0;
                        tick  = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                if (bus.goal_team1 && s1_q != 4'd15) s1_d = s1_q + 4'd1;
                if (bus.goal_team2 && s2_q != 4'd15) s2_d = s2_q + 4'd1;
                if (tick && left_q != 8'd0) left_d = left_q - 8'd1;
                // Expiry wins over a same-cycle goal: the goal still scores.
                if (tick && left_q <= 8'd1) begin
                    state_d = OVER;
                end
`ifdef GOAL_HOLD_EN
                else if (goal_any) begin
                    state_d = GOAL_HOLD;
                    hold_d  = 8'd0;
                end
`endif
            end
`ifdef GOAL_HOLD_EN
            GOAL_HOLD: begin
                if (bus.frame_end) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RUN;
                        hold_d  = 8'd0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            left_q      <= MATCH_LD;
            s1_q        <= 4'd0;
            s2_q        <= 4'd0;
            game_over_q <= 1'b0;
            freeze_q    <= 1'b1;
`ifdef GOAL_HOLD_EN
            hold_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            left_q      <= left_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            game_over_q <= (state_d == OVER);
            freeze_q    <= (state_d != RUN);
`ifdef GOAL_HOLD_EN
            hold_q      <= hold_d;
`endif
        end
    end

    // Positions latch at the end of each visible frame regardless of match state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else if (bus.frame_end) begin
            pos_q <= {bus.team2_hor_in, bus.team2_ver_in, bus.team1_hor_in,
                      bus.team1_ver_in, bus.ball_y_in, bus.ball_x_in};
        end
    end

    assign bus.ball_x        = pos_q[0];
    assign bus.ball_y        = pos_q[1];
    assign bus.team1_ver_pos = pos_q[2];
    assign bus.team1_hor_pos = pos_q[3];
    assign bus.team2_ver_pos = pos_q[4];
    assign bus.team2_hor_pos = pos_q[5];
    assign bus.left_seconds  = left_q;
    assign bus.score1        = s1_q;
    assign bus.score2        = s2_q;
    assign bus.state         = state_q;
    assign bus.game_over     = game_over_q;
    assign bus.freeze        = freeze_q;
endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer (CLK_HZ=4, MATCH_SECONDS=3, HOLD_FRAMES=2):
// vector table for the main flow plus hand sequences for goals, hold, expiry and reset.
module tb_match_sequencer;
`ifdef GOAL_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    match_sequencer_if bus();

    match_sequencer #(.CLK_HZ(4), .MATCH_SECONDS(3), .HOLD_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         start, pause, fe, g1, g2;
        logic [9:0] bx;
        int         cyc;
        logic [1:0] st;
        logic [7:0] left;
        logic [3:0] s1, s2;
        logic [9:0] ebx;
    } vec_t;

    vec_t tv[11];

    function automatic logic [9:0] pos_of(logic [9:0] b, int k);
        return (b == 10'd0) ? 10'd0 : (b ^ 10'(k));
    endfunction

    task automatic set_pos(logic [9:0] b);
        bus.ball_x_in    = pos_of(b, 0);
        bus.ball_y_in    = pos_of(b, 1);
        bus.team1_ver_in = pos_of(b, 2);
        bus.team1_hor_in = pos_of(b, 3);
        bus.team2_ver_in = pos_of(b, 4);
        bus.team2_hor_in = pos_of(b, 5);
    endtask

    // Clock n cycles from a negedge, dropping single-cycle pulses after the first edge.
    task automatic step(int n);
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.frame_end = 1'b0;
        bus.goal_team1 = 1'b0; bus.goal_team2 = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(string name, logic [1:0] st, logic [7:0] left,
                       logic [3:0] s1, logic [3:0] s2, logic [9:0] bx);
        logic pos_ok, go, fz;
        go = (st == 2'd3);
        fz = (st != 2'd1);
        pos_ok = (bus.ball_x == pos_of(bx, 0)) && (bus.ball_y == pos_of(bx, 1)) &&
                 (bus.team1_ver_pos == pos_of(bx, 2)) && (bus.team1_hor_pos == pos_of(bx, 3)) &&
                 (bus.team2_ver_pos == pos_of(bx, 4)) && (bus.team2_hor_pos == pos_of(bx, 5));
        n_tests++;
        if (bus.state !== st || bus.left_seconds !== left || bus.score1 !== s1 ||
            bus.score2 !== s2 || bus.game_over !== go || bus.freeze !== fz || !pos_ok) begin
            n_fail++;
            $display("FAIL %s: got st=%0d left=%0d s1=%0d s2=%0d go=%0b fz=%0b bx=%0d pos_ok=%0b; want st=%0d left=%0d s1=%0d s2=%0d go=%0b fz=%0b bx=%0d",
                     name, bus.state, bus.left_seconds, bus.score1, bus.score2,
                     bus.game_over, bus.freeze, bus.ball_x, pos_ok,
                     st, left, s1, s2, go, fz, bx);
        end
    endtask

    initial begin
        //          start pause fe g1 g2  bx      cyc  st    left  s1    s2    ebx
        tv[0]  = '{0, 0, 0, 0, 0, 10'd0,   2,  2'd0, 8'd3, 4'd0, 4'd0, 10'd0};
        tv[1]  = '{1, 0, 0, 0, 0, 10'd0,   1,  2'd1, 8'd3, 4'd0, 4'd0, 10'd0};
        tv[2]  = '{0, 0, 0, 0, 0, 10'd0,   3,  2'd1, 8'd3, 4'd0, 4'd0, 10'd0};
        tv[3]  = '{0, 1, 0, 0, 0, 10'd0,  10,  2'd1, 8'd3, 4'd0, 4'd0, 10'd0};
        tv[4]  = '{0, 0, 0, 0, 0, 10'd0,   1,  2'd1, 8'd2, 4'd0, 4'd0, 10'd0};
        tv[5]  = '{1, 0, 0, 0, 0, 10'd0,   1,  2'd1, 8'd2, 4'd0, 4'd0, 10'd0};
        tv[6]  = '{0, 0, 0, 0, 0, 10'd0,   7,  2'd3, 8'd0, 4'd0, 4'd0, 10'd0};
        tv[7]  = '{0, 0, 0, 1, 0, 10'd0,   1,  2'd3, 8'd0, 4'd0, 4'd0, 10'd0};
        tv[8]  = '{0, 0, 1, 0, 0, 10'd321, 1,  2'd3, 8'd0, 4'd0, 4'd0, 10'd321};
        tv[9]  = '{0, 0, 0, 0, 0, 10'd100, 1,  2'd3, 8'd0, 4'd0, 4'd0, 10'd321};
        tv[10] = '{1, 0, 0, 0, 0, 10'd100, 1,  2'd1, 8'd3, 4'd0, 4'd0, 10'd321};

        bus.start = 1'b0; bus.pause = 1'b0; bus.frame_end = 1'b0;
        bus.goal_team1 = 1'b0; bus.goal_team2 = 1'b0;
        set_pos(10'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", 2'd0, 8'd3, 4'd0, 4'd0, 10'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            bus.start = tv[i].start; bus.pause = tv[i].pause; bus.frame_end = tv[i].fe;
            bus.goal_team1 = tv[i].g1; bus.goal_team2 = tv[i].g2;
            set_pos(tv[i].bx);
            step(tv[i].cyc);
            chk($sformatf("vec%0d", i), tv[i].st, tv[i].left, tv[i].s1, tv[i].s2, tv[i].ebx);
        end

        // Both goals in one cycle, then two frame_end pulses with the timer frozen.
        bus.goal_team1 = 1'b1; bus.goal_team2 = 1'b1;
        step(1);
        chk("dual_goal", HOLD ? 2'd2 : 2'd1, 8'd3, 4'd1, 4'd1, 10'd321);
        bus.pause = 1'b1;
        bus.frame_end = 1'b1;
        step(1);
        chk("hold_fe1", HOLD ? 2'd2 : 2'd1, 8'd3, 4'd1, 4'd1, 10'd100);
        bus.frame_end = 1'b1;
        step(1);
        chk("hold_fe2", 2'd1, 8'd3, 4'd1, 4'd1, 10'd100);

        // 16 more team2 goals: score saturates at 15.
        for (int g = 0; g < 16; g++) begin
            bus.goal_team2 = 1'b1;
            step(1);
            bus.frame_end = 1'b1;
            step(1);
            bus.frame_end = 1'b1;
            step(1);
        end
        chk("sat15", 2'd1, 8'd3, 4'd1, 4'd15, 10'd100);

        // Divider sits at 1 from the dual-goal cycle; 10 clocks leaves left=1, div=3.
        bus.pause = 1'b0;
        step(10);
        chk("pre_expiry", 2'd1, 8'd1, 4'd1, 4'd15, 10'd100);
        bus.goal_team1 = 1'b1;
        step(1);
        chk("goal_on_expiry", 2'd3, 8'd0, 4'd2, 4'd15, 10'd100);
        bus.start = 1'b1;
        step(1);
        chk("restart", 2'd1, 8'd3, 4'd0, 4'd0, 10'd100);

        // Mid-frame position change is not visible until after frame_end.
        set_pos(10'd321);
        step(1);
        chk("midframe_hold", 2'd1, 8'd3, 4'd0, 4'd0, 10'd100);
        bus.frame_end = 1'b1;
        step(1);
        chk("frame_latch", 2'd1, 8'd3, 4'd0, 4'd0, 10'd321);

        // Asynchronous reset mid-RUN, then a fresh match.
        bus.goal_team1 = 1'b1;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 2'd0, 8'd3, 4'd0, 4'd0, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1;
        step(1);
        chk("fresh_start", 2'd1, 8'd3, 4'd0, 4'd0, 10'd0);
        step(4);
        chk("fresh_tick", 2'd1, 8'd2, 4'd0, 4'd0, 10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
